cache_resp_model: RTL and testbench

Responder side of the core↔cache request interface: a behavioural direct-mapped cache plus backing word memory that accepts `core2cache_*` read/write requests and answers with single-cycle `cache2core_*_fin` pulses. It sits where the real cache will sit, so that core-side traffic generators and the core itself can be brought up with deterministic hit/miss latency and observable statistics.

---
 rtl/cache_resp_model_pkg.sv | 23 ++
 rtl/cache_resp_model_if.sv | 19 +
 rtl/cache_tag_store.sv | 23 ++
 rtl/cache_resp_model.sv | 125 ++++++++++++
 tb/tb_cache_resp_model.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cache_resp_model_pkg.sv
// cache_pkg: shared widths, address slicing and FSM state type for the cache responder model.
package cache_pkg;
  localparam int ADDR_W = 27;
  localparam int TAG_W = 13;
  localparam int IDX_W = 10;
  localparam int OFF_W = 4;
  localparam int TAG_HI = 26;
  localparam int TAG_LO = 14;
  localparam int IDX_HI = 13;
  localparam int IDX_LO = 4;
  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, RESP} state_t;
  typedef struct packed {
    logic wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0] data;
  } req_t;
  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[TAG_HI:TAG_LO];
  endfunction
  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[IDX_HI:IDX_LO];
  endfunction
endpackage

// File: rtl/cache_resp_model_if.sv
// cache_resp_model_if: core<->cache request/response bus; master is the core, slave the cache.
interface cache_resp_model_if;
  logic core2cache_rd_en;
  logic [cache_pkg::ADDR_W-1:0] core2cache_rd_addr;
  logic core2cache_wr_en;
  logic [cache_pkg::ADDR_W-1:0] core2cache_wr_addr;
  logic [31:0] core2cache_wr_data;
  logic cache2core_rd_fin;
  logic [31:0] cache2core_rd_data;
  logic cache2core_wr_fin;
  modport master (
    output core2cache_rd_en, core2cache_rd_addr, core2cache_wr_en, core2cache_wr_addr, core2cache_wr_data,
    input cache2core_rd_fin, cache2core_rd_data, cache2core_wr_fin
  );
  modport slave (
    input core2cache_rd_en, core2cache_rd_addr, core2cache_wr_en, core2cache_wr_addr, core2cache_wr_data,
    output cache2core_rd_fin, cache2core_rd_data, cache2core_wr_fin
  );
endinterface

// File: rtl/cache_tag_store.sv
// cache_tag_store: direct-mapped valid bits (cleared by reset) plus tag RAM with lookup and allocate ports.
module cache_tag_store
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  input  logic             al_en,
  input  logic [IDX_W-1:0] al_idx,
  input  logic [TAG_W-1:0] al_tag
);
  logic [(1<<IDX_W)-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_ram [1<<IDX_W];
  always_comb begin
    valid_d = valid_q;
    if (al_en) valid_d[al_idx] = 1'b1;
  end
  always_ff @(posedge clk) valid_q <= rstn ? valid_d : '0;
  always_ff @(posedge clk) if (al_en) tag_ram[al_idx] <= al_tag;
  assign lk_hit = valid_q[lk_idx] && tag_ram[lk_idx] == lk_tag;
endmodule

// File: rtl/cache_resp_model.sv
// cache_resp_model: behavioural direct-mapped cache responder with fixed hit/miss latency and statistics.
module cache_resp_model
  import cache_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int HIT_LAT = 1,
  parameter int MISS_LAT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  cache_resp_model_if.slave     bus,
  output logic                  busy,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count,
  output logic                  err_overrun
);
  state_t state_q, state_d;
  req_t cur_q, cur_d, pend_q, pend_d, wr_req, rd_req;
  logic pend_v_q, pend_v_d, hit_q, hit_d, err_q, err_d, rd_fin_q, rd_fin_d, wr_fin_q, wr_fin_d;
  logic [15:0] cnt_q, cnt_d, hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] mem [1<<MEM_AW];
  logic [MEM_AW-1:0] word;
  logic lk_hit, done, take_w, take_r, mem_we, al_en, unused_ok;
  assign word = cur_q.addr[MEM_AW+1:2];
  assign unused_ok = &{1'b0, cur_q.addr[1:0]};
  assign wr_req = '{wr: 1'b1, addr: bus.core2cache_wr_addr, data: bus.core2cache_wr_data};
  assign rd_req = '{wr: 1'b0, addr: bus.core2cache_rd_addr, data: 32'h0};
  cache_tag_store u_tags (
    .clk    (clk),
    .rstn   (rstn),
    .lk_idx (idx_of(cur_q.addr)),
    .lk_tag (tag_of(cur_q.addr)),
    .lk_hit (lk_hit),
    .al_en  (al_en),
    .al_idx (idx_of(cur_q.addr)),
    .al_tag (tag_of(cur_q.addr))
  );
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    pend_v_d = pend_v_q;
    pend_d = pend_q;
    hit_d = hit_q;
    cnt_d = cnt_q;
    hit_cnt_d = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_d = err_q;
    rd_data_d = rd_data_q;
    rd_fin_d = 1'b0;
    wr_fin_d = 1'b0;
    done = 1'b0;
    take_w = bus.core2cache_wr_en;
    take_r = bus.core2cache_rd_en;
    case (state_q)
      LOOKUP: begin
        state_d = WAIT;
        hit_d = lk_hit;
        cnt_d = lk_hit ? 16'(HIT_LAT) : 16'(MISS_LAT);
        hit_cnt_d = hit_cnt_q + 16'(lk_hit && hit_cnt_q != 16'hFFFF);
        miss_cnt_d = miss_cnt_q + 16'(!lk_hit && miss_cnt_q != 16'hFFFF);
      end
      WAIT: begin
        done = cnt_q == 16'd1;
        state_d = done ? RESP : WAIT;
        cnt_d = cnt_q - 16'd1;
        wr_fin_d = done && cur_q.wr;
        rd_fin_d = done && !cur_q.wr;
        rd_data_d = rd_fin_d ? mem[word] : rd_data_q;
      end
      default: begin
        // RESP accepts like IDLE so back-to-back requests cost LAT+2 cycles
        state_d = (pend_v_q || take_w || take_r) ? LOOKUP : IDLE;
        cur_d = pend_v_q ? pend_q : take_w ? wr_req : take_r ? rd_req : cur_q;
        take_r = take_r && (pend_v_q || take_w);
        take_w = take_w && pend_v_q;
        pend_v_d = 1'b0;
      end
    endcase
    if (take_w || take_r) begin
      err_d = err_q || pend_v_d || (take_w && take_r);
      pend_d = pend_v_d ? pend_q : take_w ? wr_req : rd_req;
      pend_v_d = 1'b1;
    end
  end
  assign mem_we = rstn && done && cur_q.wr;
  assign al_en = rstn && done && !hit_q;
  always_ff @(posedge clk) if (mem_we) mem[word] <= cur_q.data;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cur_q <= '0;
      pend_v_q <= 1'b0;
      pend_q <= '0;
      hit_q <= 1'b0;
      cnt_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
      err_q <= 1'b0;
      rd_data_q <= '0;
      rd_fin_q <= 1'b0;
      wr_fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      pend_v_q <= pend_v_d;
      pend_q <= pend_d;
      hit_q <= hit_d;
      cnt_q <= cnt_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      err_q <= err_d;
      rd_data_q <= rd_data_d;
      rd_fin_q <= rd_fin_d;
      wr_fin_q <= wr_fin_d;
    end
  end
  assign bus.cache2core_rd_fin = rd_fin_q;
  assign bus.cache2core_wr_fin = wr_fin_q;
  assign bus.cache2core_rd_data = rd_data_q;
  assign busy = state_q != IDLE || pend_v_q;
  assign hit_count = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign err_overrun = err_q;
endmodule

// File: tb/tb_cache_resp_model.sv
// tb_cache_resp_model: directed and random traffic checked every cycle against a request-level model.
module tb_cache_resp_model;
  import cache_pkg::*;
  localparam int MEM_AW = 12, HIT_LAT = 1, MISS_LAT = 8;
  logic clk = 0, rstn = 0;
  logic busy, err_overrun;
  logic [15:0] hit_count, miss_count;
  int n_chk = 0, n_fail = 0;
  bit started = 0;
  cache_resp_model_if bus();
  cache_resp_model #(.MEM_AW(MEM_AW), .HIT_LAT(HIT_LAT), .MISS_LAT(MISS_LAT)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count), .err_overrun(err_overrun)
  );
  always #5 clk = ~clk;

  // request-level model: one active request with an age, one pending slot
  bit m_act = 0, m_pv = 0, m_hit = 0, m_err = 0, m_rd_fin = 0, m_wr_fin = 0, m_rd_known = 1;
  int m_age = 0, m_lat = 0;
  req_t m_cur, m_pend;
  logic [15:0] m_hits = 0, m_misses = 0;
  logic [31:0] m_rd_data = 0;
  bit m_valid [1024];
  logic [12:0] m_tag [1024];
  logic [31:0] m_mem [int];

  function automatic int widx(input logic [26:0] a);
    return int'(a[MEM_AW+1:2]);
  endfunction

  task automatic m_start(input req_t r);
    int i;
    i = int'(r.addr[13:4]);
    m_cur = r; m_act = 1; m_age = 0;
    m_hit = m_valid[i] && m_tag[i] == r.addr[26:14];
    m_lat = m_hit ? HIT_LAT : MISS_LAT;
  endtask

  always @(posedge clk) begin
    req_t wq, rq;
    bit hw, hr;
    int i;
    m_rd_fin = 0; m_wr_fin = 0;
    if (!rstn) begin
      m_act = 0; m_pv = 0; m_hits = 0; m_misses = 0; m_err = 0; m_rd_data = 0; m_rd_known = 1;
      for (int k = 0; k < 1024; k++) m_valid[k] = 0;
    end else begin
      if (m_act) begin
        m_age++;
        if (m_age == 1) begin
          if (m_hit && m_hits != 16'hFFFF) m_hits++;
          if (!m_hit && m_misses != 16'hFFFF) m_misses++;
        end
        if (m_age == m_lat + 1) begin
          if (m_cur.wr) begin m_mem[widx(m_cur.addr)] = m_cur.data; m_wr_fin = 1; end
          else begin
            m_rd_fin = 1;
            m_rd_known = m_mem.exists(widx(m_cur.addr));
            if (m_rd_known) m_rd_data = m_mem[widx(m_cur.addr)];
          end
          i = int'(m_cur.addr[13:4]);
          m_valid[i] = 1; m_tag[i] = m_cur.addr[26:14];
        end
        if (m_age == m_lat + 2) m_act = 0;
      end
      wq = '{wr: 1'b1, addr: bus.core2cache_wr_addr, data: bus.core2cache_wr_data};
      rq = '{wr: 1'b0, addr: bus.core2cache_rd_addr, data: 32'h0};
      hw = bus.core2cache_wr_en; hr = bus.core2cache_rd_en;
      if (!m_act) begin
        if (m_pv) begin m_start(m_pend); m_pv = 0; end
        else if (hw) begin m_start(wq); hw = 0; end
        else if (hr) begin m_start(rq); hr = 0; end
      end
      if (hw || hr) begin
        if (m_pv || (hw && hr)) m_err = 1;
        if (!m_pv) begin m_pv = 1; m_pend = hw ? wq : rq; end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (started) begin
    chk("rd_fin", 32'(bus.cache2core_rd_fin), 32'(m_rd_fin));
    chk("wr_fin", 32'(bus.cache2core_wr_fin), 32'(m_wr_fin));
    chk("busy", 32'(busy), 32'(m_act || m_pv));
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_misses));
    chk("err_overrun", 32'(err_overrun), 32'(m_err));
    if (m_rd_known) chk("rd_data", bus.cache2core_rd_data, m_rd_data);
  end

  function automatic logic [26:0] mk(input int t, input int i, input int o);
    return {13'(t), 10'(i), 4'(o)};
  endfunction

  task automatic step(input logic r, input logic [26:0] ra, input logic w, input logic [26:0] wa, input logic [31:0] wd);
    @(negedge clk);
    bus.core2cache_rd_en = r; bus.core2cache_rd_addr = ra;
    bus.core2cache_wr_en = w; bus.core2cache_wr_addr = wa; bus.core2cache_wr_data = wd;
  endtask

  task automatic idle();
    step(0, '0, 0, '0, '0);
  endtask

  task automatic wait_fin(output int k, output bit was_wr);
    k = 0; was_wr = 0;
    do begin idle(); k++; end while (!(bus.cache2core_rd_fin || bus.cache2core_wr_fin) && k < 40);
    was_wr = bus.cache2core_wr_fin;
    if (k >= 40) chk("fin_timeout", 32'(k), 32'd0);
  endtask

  task automatic count_fins(input int n, output int rf, output int wf);
    rf = 0; wf = 0;
    repeat (n) begin idle(); rf += int'(bus.cache2core_rd_fin); wf += int'(bus.cache2core_wr_fin); end
  endtask

  initial begin
    int k, rf, wf;
    bit w;
    logic [26:0] a1, a3, a4;
    a1 = mk(1, 'h140, 'hC); a3 = mk(3, 'h050, 4); a4 = mk(4, 'h060, 0);
    bus.core2cache_rd_en = 0; bus.core2cache_wr_en = 0;
    bus.core2cache_rd_addr = '0; bus.core2cache_wr_addr = '0; bus.core2cache_wr_data = '0;
    repeat (3) @(negedge clk);
    rstn = 1; started = 1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_hits", 32'(hit_count), 0);
    chk("reset_err", 32'(err_overrun), 0);
    step(0, '0, 1, a1, 32'h1);
    wait_fin(k, w);
    chk("wr_miss_lat", 32'(k), 10); chk("wr_kind", 32'(w), 1); chk("miss1", 32'(miss_count), 1);
    step(1, a1, 0, '0, '0);
    wait_fin(k, w);
    chk("rd_hit_lat", 32'(k), 3); chk("rd_data1", bus.cache2core_rd_data, 32'h1); chk("hit1", 32'(hit_count), 1);
    step(1, mk(2, 'h140, 0), 0, '0, '0);
    wait_fin(k, w);
    chk("alias_miss_lat", 32'(k), 10);
    step(1, a1, 0, '0, '0);
    wait_fin(k, w);
    chk("reread_lat", 32'(k), 10); chk("miss3", 32'(miss_count), 3); chk("rd_data_alias", bus.cache2core_rd_data, 32'h1);
    step(1, a3, 1, a3, 32'hA5A5);
    wait_fin(k, w);
    chk("both_first_wr", 32'(w), 1); chk("both_wr_lat", 32'(k), 10);
    wait_fin(k, w);
    chk("both_then_rd", 32'(w), 0); chk("both_rd_lat", 32'(k), 3);
    chk("raw_data", bus.cache2core_rd_data, 32'hA5A5); chk("both_err", 32'(err_overrun), 0);
    step(0, '0, 1, a4, 32'd7); step(0, '0, 1, a4, 32'd8); step(0, '0, 1, a4, 32'd9);
    count_fins(30, rf, wf);
    chk("overrun_wr_fins", 32'(wf), 2); chk("overrun_err", 32'(err_overrun), 1);
    count_fins(5, rf, wf);
    chk("err_sticky", 32'(err_overrun), 1);
    step(1, a4, 0, '0, '0);
    wait_fin(k, w);
    chk("overrun_data", bus.cache2core_rd_data, 32'd8);
    step(1, mk(5, 'h070, 0), 0, '0, '0);
    repeat (4) idle();
    idle(); rstn = 0;
    idle(); rstn = 1;
    count_fins(15, rf, wf);
    chk("rst_no_fin", 32'(rf + wf), 0); chk("rst_miss", 32'(miss_count), 0);
    chk("rst_hit", 32'(hit_count), 0); chk("rst_err", 32'(err_overrun), 0);
    step(1, a1, 0, '0, '0);
    wait_fin(k, w);
    chk("rst_cold_lat", 32'(k), 10); chk("rst_cold_miss", 32'(miss_count), 1);
    for (int i = 1; i <= 100; i++) begin
      step(0, '0, 1, mk(i, 'h200 + i, 0), 32'(i));
      wait_fin(k, w);
    end
    for (int i = 1; i <= 100; i++) begin
      step(1, mk(i, 'h200 + i, 0), 0, '0, '0);
      wait_fin(k, w);
      chk("sweep_data", bus.cache2core_rd_data, 32'(i));
    end
    chk("sweep_err", 32'(err_overrun), 0);
    for (int c = 0; c < 600; c++)
      step($urandom_range(3) == 0, mk($urandom_range(2), $urandom_range(3), $urandom_range(15)),
           $urandom_range(4) == 0, mk($urandom_range(2), $urandom_range(3), $urandom_range(15)), $urandom);
    repeat (40) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
